fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core: owns the program counter, issues word requests to instruction memory, buffers returned instructions toward decode, and applies control-flow redirects resolved by the execute-stage branch unit (its taken-branch and jump outputs, with the target, drive `redirect`/`redirect_pc`). In-flight responses from the old path are counted and discarded, so decode never sees a wrong-path instruction issued before the redirect.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count.
// Caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, decode buffer.
// Define FETCH_PERF_EN to add the redirect_cnt performance counter port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   buf_count;
  logic [XLEN-1:0] inflight_pc;
  fetch_entry_t    buf_wdata, buf_rdata;
  logic            grant, resp_keep, dec_pop, credit;

  // Buffer entries plus in-flight requests may never exceed DEPTH.
  assign credit = ({1'b0, outstanding} + {1'b0, buf_count})
                  < (CW + 1)'(DEPTH);

  assign imem_req  = !rst && !redirect && credit;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign resp_keep = imem_rvalid && !redirect && (discard_q == '0);
  assign if_valid  = (buf_count != '0) && !redirect;
  assign dec_pop   = if_valid && if_ready;

  assign buf_wdata = '{pc: inflight_pc, instr: imem_rdata};
  assign if_pc     = buf_rdata.pc;
  assign if_instr  = buf_rdata.instr;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (grant),
    .wdata (pc_q),
    .pop   (imem_rvalid),
    .rdata (inflight_pc),
    .count (outstanding)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (resp_keep),
    .wdata (buf_wdata),
    .pop   (dec_pop),
    .rdata (buf_rdata),
    .count (buf_count)
  );

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect) begin
      pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d = outstanding - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q + {31'b0, redirect};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign redirect_cnt = rcnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, corner sequences,
// and randomized traffic against an in-order path scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] s_rcnt;
`endif

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend[$];
  vec_t        tbl[9];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          pops = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gpct = 100;
  int          rpct = 100;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_rcnt = '0;
  logic [31:0] first_pc = '0;
  bit          got_first = 1'b0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, want);
  endtask

  // Memory answers ~addr; expected stream is consecutive from the last target.
  task automatic step(input logic rdy, input logic rd,
                      input logic [31:0] rpc);
    @(negedge clk);
    if_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = ($urandom_range(99) < gpct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend.size() > 0 && pend[0].rdy <= cyc
        && $urandom_range(99) < rpct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend[0].addr;
    end
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_vld  = if_valid;
    s_pc   = if_pc;
`ifdef FETCH_PERF_EN
    s_rcnt = redirect_cnt;
`endif
    if (rd) begin
      chk(!if_valid, "valid_on_redirect", {31'b0, if_valid}, 32'h0);
      chk(!imem_req, "req_on_redirect", {31'b0, imem_req}, 32'h0);
    end
    if (if_valid && if_ready) begin
      chk(if_pc == exp_pc, "pop_pc", if_pc, exp_pc);
      chk(if_instr == ~exp_pc, "pop_instr", if_instr, ~exp_pc);
      if (!got_first) begin
        first_pc  = if_pc;
        got_first = 1'b1;
      end
      pops++;
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      exp_pc   = {rpc[31:2], 2'b00};
      exp_rcnt = exp_rcnt + 32'd1;
    end
    if (imem_req && imem_gnt) begin
      chk(pend.size() < 2 && imem_addr[1:0] == 2'b00, "inflight_limit",
          32'(pend.size()), 32'd1);
      pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    end
    if (imem_rvalid) void'(pend.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst         = 1'b1;
    redirect    = 1'b0;
    if_ready    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk(imem_req == 1'b0, "rst_req", {31'b0, imem_req}, 32'h0);
    chk(if_valid == 1'b0, "rst_valid", {31'b0, if_valid}, 32'h0);
    chk(if_pc == 32'h0, "rst_pc", if_pc, 32'h0);
    chk(if_instr == 32'h0, "rst_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_EN
    chk(redirect_cnt == 32'h0, "rst_rcnt", redirect_cnt, 32'h0);
`endif
    pend.delete();
    exp_pc    = 32'h0;
    exp_rcnt  = 32'h0;
    got_first = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int p0;
    tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    tbl[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    tbl[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    tbl[8] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0);
      chk(s_req == tbl[i].req, $sformatf("tbl%0d_req", i),
          {31'b0, s_req}, {31'b0, tbl[i].req});
      if (tbl[i].req)
        chk(s_addr == tbl[i].addr, $sformatf("tbl%0d_addr", i),
            s_addr, tbl[i].addr);
      chk(s_vld == tbl[i].vld, $sformatf("tbl%0d_valid", i),
          {31'b0, s_vld}, {31'b0, tbl[i].vld});
      if (tbl[i].vld)
        chk(s_pc == tbl[i].pc, $sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
    end

    // Decode stall: credit runs out, then resumes without loss.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    chk(s_req == 1'b0, "stall_req", {31'b0, s_req}, 32'h0);
    p0 = pops;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    chk(pops - p0 >= 4, "stall_resume", 32'(pops - p0), 32'd4);

    // Two requests in flight, then redirect to 0x100.
    do_reset();
    lat_min = 4;
    lat_max = 4;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h100);
    lat_min = 1;
    lat_max = 1;
    got_first = 1'b0;
    for (int i = 0; i < 30 && !got_first; i++) step(1'b1, 1'b0, 32'h0);
    chk(got_first && first_pc == 32'h100, "discard_first_pc",
        first_pc, 32'h100);

    // Redirect coincides with a response and a would-be pop.
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk(s_vld == 1'b0, "pre_redirect_empty", {31'b0, s_vld}, 32'h0);
    step(1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b0, 32'h0);
    chk(s_req == 1'b1, "redir_req", {31'b0, s_req}, 32'h1);
    chk(s_addr == 32'h200, "redir_addr", s_addr, 32'h200);
    got_first = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    chk(got_first && first_pc == 32'h200, "redir_first_pc",
        first_pc, 32'h200);

    // PC wrap from 0xFFFF_FFFC to 0x0.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    p0 = pops;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);
    chk(pops - p0 >= 3, "wrap_progress", 32'(pops - p0), 32'd3);

    // Reset with requests outstanding.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    do_reset();
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 1'b0, 32'h0);
    chk(s_req == 1'b1, "post_rst_req", {31'b0, s_req}, 32'h1);
    chk(s_addr == 32'h0, "post_rst_addr", s_addr, 32'h0);

    // Three redirects for the perf counter.
    do_reset();
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b1, 32'hC0);
    step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    chk(s_rcnt == 32'd3, "rcnt_three", s_rcnt, 32'd3);
`endif
    do_reset();

    // Randomized traffic.
    gpct    = 70;
    rpct    = 70;
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 70, $urandom_range(99) < 5, $urandom);
    gpct = 100;
    rpct = 100;
    p0 = pops;
    for (int i = 0; i < 200 && pops - p0 < 20; i++)
      step(1'b1, 1'b0, 32'h0);
    chk(pops - p0 >= 20, "drain_progress", 32'(pops - p0), 32'd20);
`ifdef FETCH_PERF_EN
    chk(s_rcnt == exp_rcnt, "rcnt_random", s_rcnt, exp_rcnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
